// File: rtl/pipe_ctrl_unit_pkg.sv
// ctrl_pkg: control bundle, halt states and RV32I opcode constants shared by the pipeline control stage.
package ctrl_pkg;
    localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD           = 7'b0000011;
    localparam logic [6:0] OP_STORE          = 7'b0100011;
    localparam logic [6:0] OP_BRANCH         = 7'b1100011;
    localparam logic [6:0] OP_JAL            = 7'b1101111;
    localparam logic [6:0] OP_JALR           = 7'b1100111;
    localparam logic [6:0] OP_ECALL          = 7'b1110011;
    localparam logic [6:0] FUNCT7_MULDIV     = 7'b0000001;

    typedef struct packed {
        logic       is_jal;
        logic       is_jalr;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       reg_write;
        logic       pc_to_reg;
        logic       is_muldiv;
        logic [1:0] alu_src;
        logic [4:0] rd;
    } ctrl_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_e;
endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// pipe_ctrl_unit_if: ID-side inputs and ID/EX control, front-end stall and halt outputs of the control stage.
interface pipe_ctrl_unit_if;
    logic [31:0] id_inst;
    logic        id_valid, ecall_is_halt, ex_redirect;
    logic        ex_is_jal, ex_is_jalr, ex_branch, ex_mem_read, ex_mem_to_reg;
    logic        ex_mem_write, ex_reg_write, ex_pc_to_reg, ex_is_muldiv;
    logic [1:0]  ex_alu_src;
    logic [4:0]  ex_rd;
    logic        pc_write, ifid_write, ifid_flush, ex_hold, halted;

    modport master (
        output id_inst, id_valid, ecall_is_halt, ex_redirect,
        input  ex_is_jal, ex_is_jalr, ex_branch, ex_mem_read, ex_mem_to_reg,
               ex_mem_write, ex_reg_write, ex_pc_to_reg, ex_is_muldiv,
               ex_alu_src, ex_rd, pc_write, ifid_write, ifid_flush, ex_hold, halted
    );
    modport slave (
        input  id_inst, id_valid, ecall_is_halt, ex_redirect,
        output ex_is_jal, ex_is_jalr, ex_branch, ex_mem_read, ex_mem_to_reg,
               ex_mem_write, ex_reg_write, ex_pc_to_reg, ex_is_muldiv,
               ex_alu_src, ex_rd, pc_write, ifid_write, ifid_flush, ex_hold, halted
    );
endinterface

// File: rtl/pipe_ctrl_unit_decode.sv
// ctrl_decode: combinational ID-stage decode into the control bundle plus source-register usage.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int ENABLE_MULDIV = 1
) (
    input  logic [31:0] inst,
    input  logic        valid,
    output ctrl_t       ctrl,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        rs1_used,
    output logic        rs2_used,
    output logic        is_ecall
);
    logic [6:0] op;
    logic       is_ar, is_ari, is_ld, is_st, is_br, is_jal, is_jalr, is_md, rw;

    assign op       = inst[6:0];
    assign is_ar    = valid && op == OP_ARITHMETIC;
    assign is_ari   = valid && op == OP_ARITHMETIC_IMM;
    assign is_ld    = valid && op == OP_LOAD;
    assign is_st    = valid && op == OP_STORE;
    assign is_br    = valid && op == OP_BRANCH;
    assign is_jal   = valid && op == OP_JAL;
    assign is_jalr  = valid && op == OP_JALR;
    assign is_ecall = valid && op == OP_ECALL && inst[14:12] == 3'b000;
    assign is_md    = (ENABLE_MULDIV != 0) && is_ar && inst[31:25] == FUNCT7_MULDIV;
    assign rw       = is_ar || is_ari || is_ld || is_jal || is_jalr;

    // ecall reads its syscall number from x17, so it participates in load-use like rs1
    assign rs1      = is_ecall ? 5'd17 : inst[19:15];
    assign rs2      = inst[24:20];
    assign rs1_used = is_ar || is_ari || is_ld || is_st || is_br || is_jalr || is_ecall;
    assign rs2_used = is_ar || is_st || is_br;

    assign ctrl = '{
        is_jal:     is_jal,
        is_jalr:    is_jalr,
        branch:     is_br,
        mem_read:   is_ld,
        mem_to_reg: is_ld,
        mem_write:  is_st,
        reg_write:  rw,
        pc_to_reg:  is_jal || is_jalr,
        is_muldiv:  is_md,
        alu_src:    {1'b0, is_ari || is_ld || is_st || is_jalr},
        rd:         rw ? inst[11:7] : 5'd0
    };
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID/EX control register, load-use / mul-div / redirect front-end control and ecall halt drain.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int ENABLE_MULDIV = 1,
    parameter int MULDIV_LAT    = 4,
    parameter int HALT_DRAIN    = 4
) (
    input logic             clk,
    input logic             reset,
    pipe_ctrl_unit_if.slave bus
);
    localparam int BW = $clog2(MULDIV_LAT + 1);
    localparam int DW = $clog2(HALT_DRAIN + 1);

    ctrl_t         dec, ex, ex_next;
    logic [4:0]    rs1, rs2;
    logic          rs1_used, rs2_used, is_ecall;
    logic [BW-1:0] busy_cnt, busy_next;
    logic [DW-1:0] drain_cnt, drain_next;
    halt_state_e   state, state_next;
    logic          busy, freeze, load_use, halt_go, bubble;

    ctrl_decode #(.ENABLE_MULDIV(ENABLE_MULDIV)) u_decode (
        .inst     (bus.id_inst),
        .valid    (bus.id_valid),
        .ctrl     (dec),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .is_ecall (is_ecall)
    );

    assign busy     = busy_cnt != '0;
    assign freeze   = state != RUN;
    assign load_use = ex.mem_read && ex.rd != 5'd0 &&
                      ((rs1_used && rs1 == ex.rd) || (rs2_used && rs2 == ex.rd));
    // a halting ecall only counts once it actually leaves ID
    assign halt_go  = !busy && !bus.ex_redirect && !freeze && !load_use && is_ecall && bus.ecall_is_halt;
    assign bubble   = bus.ex_redirect || freeze || load_use;

    assign bus.pc_write   = !busy && (bus.ex_redirect || (!freeze && !load_use));
    assign bus.ifid_write = bus.pc_write;
    assign bus.ifid_flush = !busy && bus.ex_redirect;
    assign bus.ex_hold    = busy;
    assign bus.halted     = state == HALTED;

    always_comb begin
        ex_next    = busy ? ex : bubble ? '0 : dec;
        busy_next  = busy ? busy_cnt - 1'b1 : ex_next.is_muldiv ? BW'(MULDIV_LAT - 1) : '0;
        state_next = halt_go ? DRAIN : (state == DRAIN && drain_cnt == '0) ? HALTED : state;
        drain_next = halt_go ? DW'(HALT_DRAIN - 1) : drain_cnt != '0 ? drain_cnt - 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex        <= '0;
            busy_cnt  <= '0;
            drain_cnt <= '0;
            state     <= RUN;
        end else begin
            ex        <= ex_next;
            busy_cnt  <= busy_next;
            drain_cnt <= drain_next;
            state     <= state_next;
        end
    end

    assign bus.ex_is_jal     = ex.is_jal;
    assign bus.ex_is_jalr    = ex.is_jalr;
    assign bus.ex_branch     = ex.branch;
    assign bus.ex_mem_read   = ex.mem_read;
    assign bus.ex_mem_to_reg = ex.mem_to_reg;
    assign bus.ex_mem_write  = ex.mem_write;
    assign bus.ex_reg_write  = ex.reg_write;
    assign bus.ex_pc_to_reg  = ex.pc_to_reg;
    assign bus.ex_is_muldiv  = ex.is_muldiv;
    assign bus.ex_alu_src    = ex.alu_src;
    assign bus.ex_rd         = ex.rd;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: table-driven vectors with a scoreboard for ID/EX control, plus reset/halt corner sequences.
module tb_pipe_ctrl_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    pipe_ctrl_unit_if bus ();

    pipe_ctrl_unit #(.ENABLE_MULDIV(1), .MULDIV_LAT(4), .HALT_DRAIN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // expected control patterns: jal jalr br mr m2r mw rw p2r md alu[1:0]
    localparam logic [10:0] K_BUB  = 11'b00000000000;
    localparam logic [10:0] K_R    = 11'b00000010000;
    localparam logic [10:0] K_I    = 11'b00000010001;
    localparam logic [10:0] K_LD   = 11'b00011010001;
    localparam logic [10:0] K_ST   = 11'b00000100001;
    localparam logic [10:0] K_BR   = 11'b00100000000;
    localparam logic [10:0] K_JAL  = 11'b10000011000;
    localparam logic [10:0] K_JALR = 11'b01000011001;
    localparam logic [10:0] K_MUL  = 11'b00000010100;

    localparam logic [31:0] ADD6      = {7'd0, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33};
    localparam logic [31:0] ADDI7     = {12'd5, 5'd1, 3'd0, 5'd7, 7'h13};
    localparam logic [31:0] SW_X2     = {7'd0, 5'd2, 5'd1, 3'd2, 5'd4, 7'h23};
    localparam logic [31:0] JAL1      = {12'd0, 5'd5, 3'd0, 5'd1, 7'h6F};
    localparam logic [31:0] JALR1     = {12'd0, 5'd5, 3'd0, 5'd1, 7'h67};
    localparam logic [31:0] BAD_OP    = 32'hFFFF_FFFF;
    localparam logic [31:0] LW5       = {12'd0, 5'd1, 3'd2, 5'd5, 7'h03};
    localparam logic [31:0] SW_X5     = {7'd0, 5'd5, 5'd1, 3'd2, 5'd4, 7'h23};
    localparam logic [31:0] LW0       = {12'd0, 5'd1, 3'd2, 5'd0, 7'h03};
    localparam logic [31:0] ADD_X0    = {7'd0, 5'd2, 5'd0, 3'd0, 5'd6, 7'h33};
    localparam logic [31:0] ADDI_IMM5 = {12'd5, 5'd0, 3'd0, 5'd7, 7'h13};
    localparam logic [31:0] LW17      = {12'd0, 5'd1, 3'd2, 5'd17, 7'h03};
    localparam logic [31:0] ECALL     = 32'h0000_0073;
    localparam logic [31:0] MUL3      = {7'd1, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
    localparam logic [31:0] BEQ       = {7'd0, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63};
    localparam logic [31:0] ADDI17    = {12'd10, 5'd0, 3'd0, 5'd17, 7'h13};

    typedef struct {
        logic [31:0] inst;
        logic        valid;
        logic        halt;
        logic        redir;
        logic [3:0]  comb;
        logic [15:0] ex;
        logic        halted;
    } vec_t;

    vec_t        vq[$];
    logic [16:0] sb[$];

    function automatic logic [15:0] ex_act();
        return {bus.ex_is_jal, bus.ex_is_jalr, bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg,
                bus.ex_mem_write, bus.ex_reg_write, bus.ex_pc_to_reg, bus.ex_is_muldiv,
                bus.ex_alu_src, bus.ex_rd};
    endfunction

    function automatic logic [3:0] comb_act();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.ex_hold};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add_v(input logic [31:0] inst, input logic valid, input logic halt, input logic redir,
                         input logic [3:0] comb, input logic [10:0] k, input logic [4:0] rd,
                         input logic halted);
        vq.push_back('{inst, valid, halt, redir, comb, {k, rd}, halted});
    endtask

    task automatic drive(input logic [31:0] inst, input logic valid, input logic halt, input logic redir);
        bus.id_inst       = inst;
        bus.id_valid      = valid;
        bus.ecall_is_halt = halt;
        bus.ex_redirect   = redir;
    endtask

    // comb outputs checked before the edge; registered outputs popped from the scoreboard after it
    task automatic step(input vec_t v, input string name);
        logic [16:0] exp;
        @(negedge clk);
        drive(v.inst, v.valid, v.halt, v.redir);
        #1;
        chk({name, ".comb"}, {28'd0, comb_act()}, {28'd0, v.comb});
        sb.push_back({v.ex, v.halted});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        chk({name, ".ex"}, {15'd0, ex_act(), bus.halted}, {15'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        add_v(ADD6,      1, 0, 0, 4'b1100, K_R,    5'd6,  0);
        add_v(ADDI7,     1, 0, 0, 4'b1100, K_I,    5'd7,  0);
        add_v(SW_X2,     1, 0, 0, 4'b1100, K_ST,   5'd0,  0);
        add_v(JAL1,      1, 0, 0, 4'b1100, K_JAL,  5'd1,  0);
        add_v(JALR1,     1, 0, 0, 4'b1100, K_JALR, 5'd1,  0);
        add_v(BAD_OP,    1, 0, 0, 4'b1100, K_BUB,  5'd0,  0);
        add_v(ADD6,      0, 0, 0, 4'b1100, K_BUB,  5'd0,  0);
        add_v(LW5,       1, 0, 0, 4'b1100, K_LD,   5'd5,  0);
        add_v(ADD6,      1, 0, 0, 4'b0000, K_BUB,  5'd0,  0);
        add_v(ADD6,      1, 0, 0, 4'b1100, K_R,    5'd6,  0);
        add_v(LW5,       1, 0, 0, 4'b1100, K_LD,   5'd5,  0);
        add_v(SW_X5,     1, 0, 0, 4'b0000, K_BUB,  5'd0,  0);
        add_v(SW_X5,     1, 0, 0, 4'b1100, K_ST,   5'd0,  0);
        add_v(LW0,       1, 0, 0, 4'b1100, K_LD,   5'd0,  0);
        add_v(ADD_X0,    1, 0, 0, 4'b1100, K_R,    5'd6,  0);
        add_v(LW5,       1, 0, 0, 4'b1100, K_LD,   5'd5,  0);
        add_v(ADDI_IMM5, 1, 0, 0, 4'b1100, K_I,    5'd7,  0);
        add_v(LW5,       1, 0, 0, 4'b1100, K_LD,   5'd5,  0);
        add_v(JAL1,      1, 0, 0, 4'b1100, K_JAL,  5'd1,  0);
        add_v(LW17,      1, 0, 0, 4'b1100, K_LD,   5'd17, 0);
        add_v(ECALL,     1, 0, 0, 4'b0000, K_BUB,  5'd0,  0);
        add_v(ECALL,     1, 0, 0, 4'b1100, K_BUB,  5'd0,  0);
        add_v(MUL3,      1, 0, 0, 4'b1100, K_MUL,  5'd3,  0);
        add_v(ADD6,      1, 0, 0, 4'b0001, K_MUL,  5'd3,  0);
        add_v(ADD6,      1, 0, 1, 4'b0001, K_MUL,  5'd3,  0);
        add_v(ADD6,      1, 0, 0, 4'b0001, K_MUL,  5'd3,  0);
        add_v(ADD6,      1, 0, 0, 4'b1100, K_R,    5'd6,  0);
        add_v(BEQ,       1, 0, 0, 4'b1100, K_BR,   5'd0,  0);
        add_v(ECALL,     1, 1, 1, 4'b1110, K_BUB,  5'd0,  0);
        add_v(ADD6,      1, 0, 0, 4'b1100, K_R,    5'd6,  0);
        add_v(ADDI17,    1, 0, 0, 4'b1100, K_I,    5'd17, 0);
        add_v(ECALL,     1, 1, 0, 4'b1100, K_BUB,  5'd0,  0);
        add_v(ADD6,      1, 0, 0, 4'b0000, K_BUB,  5'd0,  0);
        add_v(ADD6,      1, 0, 0, 4'b0000, K_BUB,  5'd0,  0);
        add_v(ADD6,      1, 0, 0, 4'b0000, K_BUB,  5'd0,  0);
        add_v(ADD6,      1, 0, 0, 4'b0000, K_BUB,  5'd0,  1);

        // reset state, including ifid_flush following ex_redirect while in reset
        #1;
        chk("rst.ex", {15'd0, ex_act(), bus.halted}, 32'd0);
        chk("rst.comb", {28'd0, comb_act()}, 32'b1100);
        bus.ex_redirect = 1'b1;
        #1;
        chk("rst.flush", {28'd0, comb_act()}, 32'b1110);
        bus.ex_redirect = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("halted_hold%0d", i), {29'd0, bus.pc_write, bus.ifid_write, bus.halted}, 32'b001);
        end

        // asynchronous reset out of HALTED
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_halted", {11'd0, ex_act(), comb_act(), bus.halted}, {11'd0, 16'd0, 4'b1100, 1'b0});
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // reset mid-DRAIN
        step('{ECALL, 1, 1, 0, 4'b1100, {K_BUB, 5'd0}, 0}, "drain_go");
        step('{ADD6, 1, 0, 0, 4'b0000, {K_BUB, 5'd0}, 0}, "drain1");
        #2;
        reset = 1'b0;
        #1;
        chk("rst_drain", {11'd0, ex_act(), comb_act(), bus.halted}, {11'd0, 16'd0, 4'b1100, 1'b0});
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // reset mid-mul/div
        step('{MUL3, 1, 0, 0, 4'b1100, {K_MUL, 5'd3}, 0}, "mul_go");
        @(negedge clk);
        drive(ADD6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("mul_busy", {28'd0, comb_act()}, 32'b0001);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_busy", {11'd0, ex_act(), comb_act(), bus.halted}, {11'd0, 16'd0, 4'b1100, 1'b0});
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
